// File: rtl/stage1_window.sv
// 3x3 window front stage: two line buffers, a shifting window, and the absolute
// differences of every tap against the centre. Optional `sof` port under STAGE1_SOF_EN.

module stage1_absdiff (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] d_o
);
  logic [8:0] sub;

  // Only the low byte is needed after negation; |a-b| never exceeds 255.
  assign sub = {1'b0, a_i} - {1'b0, b_i};
  assign d_o = sub[8] ? (~sub[7:0] + 8'd1) : sub[7:0];
endmodule

module stage1_window #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
`ifdef STAGE1_SOF_EN
  input  logic       sof,
`endif
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] p4,
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8,
  output logic [7:0] p9,
  output logic [7:0] c1,
  output logic [7:0] c2,
  output logic [7:0] c3,
  output logic [7:0] c4,
  output logic [7:0] c5,
  output logic [7:0] c6,
  output logic [7:0] c7,
  output logic [7:0] c8,
  output logic [7:0] c9,
  output logic       win_valid
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic          sof_hit;
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [7:0]    lb0_q [IMG_WIDTH];
  logic [7:0]    lb1_q [IMG_WIDTH];
  logic [7:0]    lb0_rd, lb1_rd;
  logic [2:0][2:0][7:0] win_q, win_d;
  logic [8:0][7:0] diff, c_q;
  logic          valid_q, valid_d;

`ifdef STAGE1_SOF_EN
  assign sof_hit = pix_valid & sof;
`else
  assign sof_hit = 1'b0;
`endif

  // An accepted sof pixel is taken as (0,0) regardless of the counters.
  assign col_cur = sof_hit ? '0 : col_q;
  assign row_cur = sof_hit ? '0 : row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (col_cur == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_cur == RW'(IMG_HEIGHT - 1)) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers carry no reset; stale lines are masked by the row gating.
  assign lb0_rd = lb0_q[col_cur];
  assign lb1_rd = lb1_q[col_cur];

  always_ff @(posedge clk) begin
    if (rst && pix_valid) begin
      lb1_q[col_cur] <= lb0_q[col_cur];
      lb0_q[col_cur] <= pix_in;
    end
  end

  always_comb begin
    win_d = win_q;
    if (pix_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = pix_in;
    end
  end

  assign valid_d = pix_valid && (row_cur >= RW'(2)) && (col_cur >= CW'(2));

  for (genvar i = 0; i < 9; i++) begin : g_diff
    stage1_absdiff u_ad (
      .a_i (win_d[i/3][i%3]),
      .b_i (win_d[1][1]),
      .d_o (diff[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      win_q   <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      valid_q <= valid_d;
      if (pix_valid) c_q <= diff;
    end
  end

  assign p1 = win_q[0][0];
  assign p2 = win_q[0][1];
  assign p3 = win_q[0][2];
  assign p4 = win_q[1][0];
  assign p5 = win_q[1][1];
  assign p6 = win_q[1][2];
  assign p7 = win_q[2][0];
  assign p8 = win_q[2][1];
  assign p9 = win_q[2][2];
  assign c1 = c_q[0];
  assign c2 = c_q[1];
  assign c3 = c_q[2];
  assign c4 = c_q[3];
  assign c5 = c_q[4];
  assign c6 = c_q[5];
  assign c7 = c_q[6];
  assign c8 = c_q[7];
  assign c9 = c_q[8];
  assign win_valid = valid_q;
endmodule

// File: tb/tb_stage1_window.sv
// Directed and randomized bench for stage1_window on a 4x4 frame, checked
// against an image-array reference model of the neighbourhood rules.

module tb_stage1_window;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof_drv;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic [7:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
  logic       win_valid;

  always #5 clk = ~clk;

  stage1_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
`ifdef STAGE1_SOF_EN
    .sof(sof_drv),
`endif
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8), .c9(c9),
    .win_valid(win_valid)
  );

  wire [71:0] obs_p = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
  wire [71:0] obs_c = {c1, c2, c3, c4, c5, c6, c7, c8, c9};

  int checks = 0;
  int failures = 0;
  int mr = 0, mc = 0;
  logic [7:0] img [H][W];
  logic        exp_valid = 1'b0;
  logic [71:0] exp_p = '0, exp_c = '0;
  bit          known = 1'b0;
  int          wcount = 0;
  logic [71:0] first_p, first_c;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the reference model, check after the edge.
  task automatic cyc(input bit v, input logic [7:0] px, input bit s, input bit rn);
    rst = rn; pix_valid = v; pix_in = px; sof_drv = s;
    if (!rn) begin
      mr = 0; mc = 0; exp_valid = 1'b0; exp_p = '0; exp_c = '0; known = 1'b1;
    end else if (v) begin
`ifdef STAGE1_SOF_EN
      if (s) begin mr = 0; mc = 0; end
`endif
      img[mr][mc] = px;
      if (mr >= 2 && mc >= 2) begin
        int ctr;
        ctr = int'(img[mr-1][mc-1]);
        for (int i = 0; i < 9; i++) begin
          int t, d;
          t = int'(img[mr-2+i/3][mc-2+i%3]);
          d = t - ctr;
          if (d < 0) d = -d;
          exp_p[71-8*i -: 8] = t[7:0];
          exp_c[71-8*i -: 8] = d[7:0];
        end
        exp_valid = 1'b1; known = 1'b1;
      end else begin
        exp_valid = 1'b0; known = 1'b0;
      end
      mc++;
      if (mc == W) begin
        mc = 0; mr++;
        if (mr == H) mr = 0;
      end
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("win_valid", {71'b0, win_valid}, {71'b0, exp_valid});
    if (known) begin
      chk("taps", obs_p, exp_p);
      chk("diffs", obs_c, exp_c);
    end
    if (win_valid) wcount++;
  endtask

  function automatic logic [7:0] pv(input int mode, input int r, input int c);
    case (mode)
      0:       pv = 8'(16 * r + c);
      1:       pv = (r == 1 && c == 1) ? 8'h00 : 8'hFF;
      2:       pv = (r == 1 && c == 1) ? 8'hFF : 8'h00;
      default: pv = 8'($urandom);
    endcase
  endfunction

  // Stream raster pixels with index start..stop-1; bub is the bubble percentage.
  task automatic frame(input int mode, input int bub, input int start, input int stop);
    for (int k = start; k < stop; k++) begin
      while (bub > 0 && $urandom_range(99) < bub) cyc(1'b0, 8'($urandom), 1'b0, 1'b1);
      cyc(1'b1, pv(mode, k / W, k % W), 1'b0, 1'b1);
      if (k == 2 * W + 2) begin first_p = obs_p; first_c = obs_c; end
    end
  endtask

  initial begin
    rst = 1'b0; pix_valid = 1'b0; pix_in = '0; sof_drv = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);

    // Continuous ramp frame, twice
    for (int f = 0; f < 2; f++) begin
      wcount = 0;
      frame(0, 0, 0, W * H);
      chk("frame_count", 72'(wcount), 72'd4);
      chk("first_taps", first_p, 72'h000102101112202122);
      chk("first_diffs", first_c, 72'h11100F0100010F1011);
    end

    // Same frame with bubbles
    wcount = 0;
    frame(0, 50, 0, W * H);
    chk("bubble_count", 72'(wcount), 72'd4);
    chk("bubble_taps", first_p, 72'h000102101112202122);

    // Difference extremes
    frame(1, 0, 0, W * H);
    chk("ext_lo_centre", first_c, 72'hFFFFFFFF00FFFFFFFF);
    frame(2, 0, 0, W * H);
    chk("ext_hi_centre", first_c, 72'hFFFFFFFF00FFFFFFFF);

    // Mid-frame reset at pixel (2,3), then a full restart
    frame(0, 0, 0, 2 * W + 3);
    cyc(1'b1, pv(0, 2, 3), 1'b0, 1'b0);
    chk("rst_taps_zero", obs_p, 72'h0);
    chk("rst_valid_zero", {71'b0, win_valid}, 72'h0);
    wcount = 0;
    frame(0, 0, 0, W * H);
    chk("rst_restart_count", 72'(wcount), 72'd4);
    chk("rst_restart_taps", first_p, 72'h000102101112202122);
    chk("rst_restart_diffs", first_c, 72'h11100F0100010F1011);

    // Random content with random gaps
    for (int f = 0; f < 3; f++) begin
      wcount = 0;
      frame(3, 30, 0, W * H);
      chk("rand_count", 72'(wcount), 72'd4);
    end

`ifdef STAGE1_SOF_EN
    // sof at pixel (1,2) realigns the frame
    frame(0, 0, 0, W + 2);
    wcount = 0;
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    frame(0, 0, 1, W * H);
    chk("sof_count", 72'(wcount), 72'd4);
    chk("sof_first_taps", first_p, 72'h000102101112202122);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    frame(0, 0, 0, W * H);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stage1_window.md
# stage1_window

Front stage of the 3x3 neighbourhood pipeline: accepts a raster-order 8-bit pixel stream, buffers two image lines, and emits one complete 3x3 window per accepted pixel once the window is fully populated. For every window it also computes the absolute difference of each tap against the centre pixel. It drives the window taps `p1..p9` and differences `c1..c9` of the downstream squaring stage directly, registered.

## Interface
- `IMG_WIDTH`, 64: pixels per line; must be ≥ 3.
- `IMG_HEIGHT`, 64: lines per frame; must be ≥ 3.
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `pix_in`  in  8  input pixel, unsigned.
- `pix_valid`  in  1  `pix_in` is accepted this cycle; there is no backpressure.
- `sof`  in  1  start of frame, qualified by `pix_valid` (present only with `STAGE1_SOF_EN`).
- `p1..p9`  out  8 each  window taps in row-major order; `p1` is top-left, `p5` is the centre, `p9` is bottom-right.
- `c1..c9`  out  8 each  `|p_i - p5|`; `c5` is always 0.
- `win_valid`  out  1  `p*` and `c*` hold a valid window this cycle.

## Operation
- **Position counters.** `col` counts 0..IMG_WIDTH-1 and `row` counts 0..IMG_HEIGHT-1.
  - Both advance only on an accepted pixel.
  - `col` wraps to 0 after IMG_WIDTH-1 and increments `row`.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and the next frame starts.
- **Line buffers.** There are two, each IMG_WIDTH deep, indexed by `col`.
  - On acceptance, LB0[col] is read out as pixel (row-1, col) and LB1[col] as pixel (row-2, col).
  - In the same cycle, LB1[col] ← old LB0[col] and LB0[col] ← `pix_in`.
  - Buffer contents are not reset; stale data is masked by the `row` gating below.
- **Window register.** A 3x3 register shifts left by one column on each accepted pixel.
  - The new right column is {LB1 out, LB0 out, `pix_in`}, top to bottom.
  - When pixel (r,c) is accepted, the window covers rows r-2..r and columns c-2..c; the centre is (r-1, c-1).
- **Valid condition.** The window is valid when the pixel is accepted AND row ≥ 2 AND col ≥ 2.
  - Output is valid windows only, with no border padding: exactly (IMG_HEIGHT-2)·(IMG_WIDTH-2) windows per frame.
  - At the start of each line, window columns left over from the previous line shift out while col < 2 and are never flagged valid.
- **Differences.** Each `c_i` is computed as a 9-bit subtract of `p_i - p5`, conditionally negated, and truncated to 8 bits.
  - The result is always in 0..255 and never saturates.

## Timing
- **Latency.** `p*`, `c*` and `win_valid` are registered: 1 cycle after the accepting edge for pixel (r,c).
- **Idle cycles.** `win_valid` is high for exactly one cycle per valid window.
  - `pix_valid` = 0 cycles insert bubbles: `win_valid` goes to 0, and `p*`/`c*` hold their last values.
  - Back-to-back valid pixels give back-to-back valid windows at full rate.
- **Reset.**
  - While `rst` = 0 at the clock edge: all `p*`, `c*` and `win_valid` become 0, and `row`/`col` become 0.
  - Window registers become 0; line buffers are untouched.
  - A reset mid-frame aborts the frame: the first pixel accepted after reset is treated as (0,0).
- **Reset priority.** Reset has priority over `pix_valid` in the same cycle; that pixel is dropped.

## Configuration
- **`STAGE1_SOF_EN` defined.**
  - The `sof` port exists.
  - An accepted pixel with `sof` = 1 is forced to position (0,0) regardless of the counters; the counters then continue from (0,1).
  - Windows in flight from the truncated frame are dropped, because the row < 2 gating applies.
  - `sof` without `pix_valid` is ignored.
- **`STAGE1_SOF_EN` undefined.**
  - No `sof` port.
  - Frame alignment comes only from `rst` and the counter wrap.

## Test plan
- **First window.** IMG_WIDTH = IMG_HEIGHT = 4, continuous pixels with value 16·row+col.
  - Stimulus: accept pixel (2,2) (value 0x22).
  - Next cycle: `win_valid` = 1, `p1..p9` = 00,01,02,10,11,12,20,21,22 and `c1..c9` = 11,10,0F,01,00,01,0F,10,11 (hex).
- **Frame count and order.** Same 4x4 frame streamed twice.
  - Exactly 4 valid windows per frame, centres at 11,12,21,22; the second frame gives identical values.
  - No `win_valid` while row < 2 or col < 2.
- **Bubbles.** Same frame with `pix_valid` toggling randomly (~50%).
  - Windows and values identical to the continuous run.
  - `win_valid` is never high in the cycle after a `pix_valid` = 0 cycle, and outputs hold during gaps.
- **Difference extremes.**
  - Centre 0x00 with all neighbours 0xFF → every `c_i` except `c5` = 0xFF.
  - Centre 0xFF with all neighbours 0x00 → every `c_i` except `c5` = 0xFF.
- **Mid-frame reset.** Drive `rst` = 0 for 1 cycle at pixel (2,3), then restart the frame.
  - All outputs 0 the cycle after reset.
  - The next valid window appears only after new pixel (2,2), and its values match scenario 1.
- **SOF (`STAGE1_SOF_EN` only).** Assert `sof` at pixel (1,2) of a frame.
  - That pixel becomes (0,0); no window is produced until new pixel (2,2).
  - Then exactly 4 valid windows follow for the realigned frame.
